// File: rtl/hex_mem_arbiter.sv
// hex_mem_arbiter: shares one single-ported data memory between NUM_PORTS
// requesters. The grant is combinational (round-robin or fixed priority).
// Each read or write response comes back exactly one cycle after its grant,
// and it is routed to the port that issued it.
module hex_mem_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_WIDTH     = 18,
   parameter int DATA_WIDTH     = 32,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [NUM_PORTS-1:0]            i_req_valid,
   input  logic [NUM_PORTS-1:0]            i_req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_PORTS-1:0]            o_req_ready,
   output logic [NUM_PORTS-1:0]            o_rsp_valid,
   output logic [DATA_WIDTH-1:0]           o_rsp_data,
   output logic                            o_mem_valid,
   output logic                            o_mem_we,
   output logic [ADDR_WIDTH-1:0]           o_mem_addr,
   output logic [DATA_WIDTH-1:0]           o_mem_data,
   input  logic [DATA_WIDTH-1:0]           i_mem_data
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

   logic [PTR_W-1:0]      ptr_r;
   logic [PTR_W-1:0]      base_s;
   logic [PTR_W-1:0]      gidx_s;
   logic                  found_s;
   logic [NUM_PORTS-1:0]  grant_s;
   logic                  tag_valid_r;
   logic                  tag_we_r;
   logic [PTR_W-1:0]      tag_port_r;
   logic [ADDR_WIDTH-1:0] addr_a_s [NUM_PORTS];
   logic [DATA_WIDTH-1:0] data_a_s [NUM_PORTS];

   // Port index reached after stepping k places from base, wrapping at NUM_PORTS.
   function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_PORTS) begin
         s = s - NUM_PORTS;
      end else begin
         s = s;
      end
      return PTR_W'(s);
   endfunction

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
      assign addr_a_s[p] = i_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_a_s[p] = i_req_data[p*DATA_WIDTH +: DATA_WIDTH];
   end

   // Fixed priority always scans from port 0; round-robin scans from the pointer.
   assign base_s = (FIXED_PRIORITY != 0) ? '0 : ptr_r;

   // Find the first requesting port in scan order; nothing wins while in reset.
   always_comb begin
      found_s = 1'b0;
      gidx_s  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!i_rst && !found_s && i_req_valid[scan_idx(base_s, k)]) begin
            found_s = 1'b1;
            gidx_s  = scan_idx(base_s, k);
         end else begin
            found_s = found_s;
            gidx_s  = gidx_s;
         end
      end
   end

   // One-hot grant decode.
   always_comb begin
      grant_s = '0;
      if (found_s) begin
         grant_s[gidx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   // Route the granted port's request to memory. The request fields are zero when idle.
   always_comb begin
      o_mem_we   = 1'b0;
      o_mem_addr = '0;
      o_mem_data = '0;
      if (found_s) begin
         o_mem_we   = i_req_we[gidx_s];
         o_mem_addr = addr_a_s[gidx_s];
         o_mem_data = data_a_s[gidx_s];
      end else begin
         o_mem_we   = 1'b0;
         o_mem_addr = '0;
         o_mem_data = '0;
      end
   end

   assign o_req_ready = grant_s;
   assign o_mem_valid = |(i_req_valid & grant_s);

   // Round-robin pointer moves to the port after the winner. It holds when there is no grant.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_r <= '0;
      end else if ((FIXED_PRIORITY == 0) && found_s) begin
         ptr_r <= (gidx_s == LAST_PORT) ? '0 : gidx_s + 1'b1;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Response tag: records which port was granted, and whether it wrote, for the next cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tag_valid_r <= 1'b0;
         tag_we_r    <= 1'b0;
         tag_port_r  <= '0;
      end else begin
         tag_valid_r <= found_s;
         tag_we_r    <= found_s & o_mem_we;
         tag_port_r  <= gidx_s;
      end
   end

   // Response strobe to the tagged port. It is suppressed while reset is held, so an in-flight response is dropped.
   always_comb begin
      o_rsp_valid = '0;
      if (tag_valid_r && !i_rst) begin
         o_rsp_valid[tag_port_r] = 1'b1;
      end else begin
         o_rsp_valid = '0;
      end
   end

   // Read data passes straight from memory. Write acknowledges carry zero.
   always_comb begin
      if (tag_valid_r && !tag_we_r && !i_rst) begin
         o_rsp_data = i_mem_data;
      end else begin
         o_rsp_data = '0;
      end
   end

endmodule

// File: tb/tb_hex_mem_arbiter.sv
// Bench for hex_mem_arbiter: a round-robin and a fixed-priority instance
// (3 ports each) share the same stimulus. A behavioural model predicts every
// output on every cycle, and directed steps pin literal expectations.
module tb_hex_mem_arbiter;

   localparam int N  = 3;
   localparam int AW = 18;
   localparam int DW = 32;
   localparam int MW = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_we;
   logic [AW-1:0] addr_a  [N];
   logic [DW-1:0] wdata_a [N];
   logic [N*AW-1:0] addr_p;
   logic [N*DW-1:0] data_p;

   for (genvar p = 0; p < N; p++) begin : g_pack
      assign addr_p[p*AW +: AW] = addr_a[p];
      assign data_p[p*DW +: DW] = wdata_a[p];
   end

   logic [N-1:0]  ready_s     [2];
   logic [N-1:0]  rsp_valid_s [2];
   logic [DW-1:0] rsp_data_s  [2];
   logic          mem_valid_s [2];
   logic          mem_we_s    [2];
   logic [AW-1:0] mem_addr_s  [2];
   logic [DW-1:0] mem_data_s  [2];
   logic [DW-1:0] mem_rdata   [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      hex_mem_arbiter #(
         .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(gi)
      ) u_dut (
         .i_clk(clk), .i_rst(rst),
         .i_req_valid(req_valid), .i_req_we(req_we),
         .i_req_addr(addr_p), .i_req_data(data_p),
         .o_req_ready(ready_s[gi]), .o_rsp_valid(rsp_valid_s[gi]),
         .o_rsp_data(rsp_data_s[gi]), .o_mem_valid(mem_valid_s[gi]),
         .o_mem_we(mem_we_s[gi]), .o_mem_addr(mem_addr_s[gi]),
         .o_mem_data(mem_data_s[gi]), .i_mem_data(mem_rdata[gi])
      );
   end

   // Memory environment (driven by the DUT) and the model's own memory view.
   logic [DW-1:0] env_mem [2][MW];
   logic [DW-1:0] mdl_mem [2][MW];
   int            m_ptr     [2];
   logic          pend_v    [2];
   int            pend_port [2];
   logic [DW-1:0] pend_data [2];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [DW-1:0] init_word(input int a);
      return (a == 16) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(a));
   endfunction

   // Winner under the arbitration rules: first valid port scanning from start, modulo N.
   function automatic int pick(input logic [N-1:0] v, input int ptr, input bit fp);
      int start;
      start = fp ? 0 : ptr;
      for (int k = 0; k < N; k++) begin
         if (v[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic int gsel(input int k);
      return pick(req_valid, m_ptr[k], k == 1);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
   endtask

   // Single-port memory with one-cycle read latency, serving each DUT.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int a = 0; a < MW; a++) env_mem[k][a] <= init_word(a);
            mem_rdata[k] <= '0;
         end else if (mem_valid_s[k]) begin
            mem_rdata[k] <= env_mem[k][mem_addr_s[k][5:0]];
            if (mem_we_s[k]) env_mem[k][mem_addr_s[k][5:0]] <= mem_data_s[k];
         end
      end
   end

   // Model state advance: the pointer, the pending response and the model memory.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_ptr[k]     <= 0;
            pend_v[k]    <= 1'b0;
            pend_port[k] <= 0;
            pend_data[k] <= '0;
            for (int a = 0; a < MW; a++) mdl_mem[k][a] <= init_word(a);
         end else if (gsel(k) >= 0) begin
            pend_v[k]    <= 1'b1;
            pend_port[k] <= gsel(k);
            pend_data[k] <= req_we[gsel(k)] ? '0 : mdl_mem[k][addr_a[gsel(k)][5:0]];
            if (req_we[gsel(k)]) mdl_mem[k][addr_a[gsel(k)][5:0]] <= wdata_a[gsel(k)];
            if (k == 0) m_ptr[k] <= (gsel(k) + 1) % N;
         end else begin
            pend_v[k] <= 1'b0;
         end
      end
   end

   task automatic check_inst(input int k);
      int g;
      logic [N-1:0] er;
      logic [N-1:0] erv;
      logic live;
      g = rst ? -1 : gsel(k);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      live = !rst && pend_v[k];
      erv = '0;
      if (live) erv[pend_port[k]] = 1'b1;
      chk($sformatf("i%0d ready", k), 64'(ready_s[k]), 64'(er));
      chk($sformatf("i%0d mem_valid", k), 64'(mem_valid_s[k]), 64'(g >= 0));
      chk($sformatf("i%0d mem_we", k), 64'(mem_we_s[k]), 64'((g >= 0) ? req_we[g] : 1'b0));
      chk($sformatf("i%0d mem_addr", k), 64'(mem_addr_s[k]), 64'((g >= 0) ? addr_a[g] : '0));
      chk($sformatf("i%0d mem_data", k), 64'(mem_data_s[k]), 64'((g >= 0) ? wdata_a[g] : '0));
      chk($sformatf("i%0d rsp_valid", k), 64'(rsp_valid_s[k]), 64'(erv));
      chk($sformatf("i%0d rsp_data", k), 64'(rsp_data_s[k]), 64'(live ? pend_data[k] : '0));
   endtask

   // Per-cycle comparison of both DUTs against the model, away from the active edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) check_inst(k);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 3'b111;
      req_we = '0;
      for (int p = 0; p < N; p++) begin
         addr_a[p] = '0;
         wdata_a[p] = '0;
      end
      @(negedge clk);
      chk("rst ready rr", 64'(ready_s[0]), 64'(3'b000));
      chk("rst ready fp", 64'(ready_s[1]), 64'(3'b000));
      chk("rst mem_valid", 64'(mem_valid_s[0]), 64'(1'b0));
      tick; tick;
      rst = 1'b0; req_valid = 3'b000;
      @(negedge clk);
      chk("idle rsp_valid", 64'(rsp_valid_s[0]), 64'(3'b000));
      chk("idle rsp_data", 64'(rsp_data_s[0]), 64'(32'h0));
      chk("idle mem_addr", 64'(mem_addr_s[0]), 64'(18'h0));
      // Port 0 reads 0x10.
      tick; req_valid = 3'b001; addr_a[0] = 18'h10;
      @(negedge clk);
      chk("rd ready", 64'(ready_s[0]), 64'(3'b001));
      chk("rd mem_valid", 64'(mem_valid_s[0]), 64'(1'b1));
      chk("rd mem_addr", 64'(mem_addr_s[0]), 64'(18'h10));
      // Port 1 writes 0x12345678 to 0x20.
      tick; req_valid = 3'b010; req_we = 3'b010; addr_a[1] = 18'h20; wdata_a[1] = 32'h12345678;
      @(negedge clk);
      chk("rd rsp_valid", 64'(rsp_valid_s[0]), 64'(3'b001));
      chk("rd rsp_data", 64'(rsp_data_s[0]), 64'(32'hDEADBEEF));
      chk("wr ready", 64'(ready_s[0]), 64'(3'b010));
      // Port 0 reads 0x20 back.
      tick; req_valid = 3'b001; req_we = 3'b000; addr_a[0] = 18'h20;
      @(negedge clk);
      chk("wr ack", 64'(rsp_valid_s[0]), 64'(3'b010));
      chk("wr ack data", 64'(rsp_data_s[0]), 64'(32'h0));
      chk("rdback ready", 64'(ready_s[0]), 64'(3'b001));
      // Pointer is at 1 with ports 0 and 2 requesting: port 2 wins, then the pointer wraps to port 0.
      tick; req_valid = 3'b101; addr_a[0] = 18'h5; addr_a[2] = 18'h6;
      @(negedge clk);
      chk("rdback data rr", 64'(rsp_data_s[0]), 64'(32'h12345678));
      chk("rdback data fp", 64'(rsp_data_s[1]), 64'(32'h12345678));
      chk("wrap rr first", 64'(ready_s[0]), 64'(3'b100));
      chk("wrap fp", 64'(ready_s[1]), 64'(3'b001));
      tick;
      @(negedge clk);
      chk("wrap rr second", 64'(ready_s[0]), 64'(3'b001));
      // Ports 0 and 1 contend for four cycles.
      tick; req_valid = 3'b011;
      for (int i = 0; i < 4; i++) begin
         logic [N-1:0] alt;
         if (i > 0) tick;
         alt = (i % 2 == 0) ? 3'b010 : 3'b001;
         @(negedge clk);
         chk($sformatf("rr alternate %0d", i), 64'(ready_s[0]), 64'(alt));
         chk($sformatf("fp hold %0d", i), 64'(ready_s[1]), 64'(3'b001));
      end
      tick; req_valid = 3'b010;
      @(negedge clk);
      chk("fp port0 drop", 64'(ready_s[1]), 64'(3'b010));
      // Reset arrives in the cycle after a grant.
      tick; req_valid = 3'b001; addr_a[0] = 18'h10;
      @(negedge clk);
      chk("pre-rst grant", 64'(ready_s[0]), 64'(3'b001));
      tick; rst = 1'b1; req_valid = 3'b011;
      @(negedge clk);
      chk("rst drop rsp", 64'(rsp_valid_s[0]), 64'(3'b000));
      chk("rst ready", 64'(ready_s[0]), 64'(3'b000));
      tick; rst = 1'b0;
      @(negedge clk);
      chk("post-rst rsp", 64'(rsp_valid_s[0]), 64'(3'b000));
      chk("post-rst ptr", 64'(ready_s[0]), 64'(3'b001));
      // Randomised traffic with occasional resets.
      for (int c = 0; c < 600; c++) begin
         tick;
         rst = ($urandom_range(0, 49) == 0);
         req_valid = 3'($urandom);
         req_we = 3'($urandom);
         for (int p = 0; p < N; p++) begin
            addr_a[p] = 18'($urandom_range(0, MW - 1));
            wdata_a[p] = $urandom;
         end
      end
      tick;
      rst = 1'b0; req_valid = '0;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
